// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types and constants for the Fig2 shift-add multiplier datapath and control FSM
package sm_pkg;

    localparam logic RST_ACTIVE   = 1'b1;
    localparam logic FLAG_RST_VAL = 1'b0;

    // Running-sum operation after priority resolution: clear > load > shift.
    typedef enum logic [1:0] {
        RS_HOLD  = 2'd0,
        RS_CLEAR = 2'd1,
        RS_LOAD  = 2'd2,
        RS_SHR   = 2'd3
    } rs_op_e;

    function automatic int RS_W(input int width);
        return 2 * width + 1;
    endfunction

    function automatic rs_op_e rs_op_decode(input logic clr, input logic ld, input logic shr);
        if (clr)
            return RS_CLEAR;
        else if (ld)
            return RS_LOAD;
        else if (shr)
            return RS_SHR;
        else
            return RS_HOLD;
    endfunction

    function automatic logic multi_strobe(input logic clr, input logic ld, input logic shr);
        return (clr & ld) | (clr & shr) | (ld & shr);
    endfunction

endpackage

// File: rtl/sm_result_buf.sv
// rtl/sm_result_buf.sv - product holding register with valid/ready handshake and sticky drop flag
module sm_result_buf
    import sm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done,
    input  logic [W-1:0] candidate,
    input  logic         prod_ready,
    output logic [W-1:0] product,
    output logic         prod_valid,
    output logic         result_ovf
);

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            product    <= '0;
            prod_valid <= FLAG_RST_VAL;
            result_ovf <= FLAG_RST_VAL;
        end else if (done) begin
            // A new result may replace the held one only if it is consumed on this same edge.
            if (!prod_valid || prod_ready) begin
                product    <= candidate;
                prod_valid <= 1'b1;
            end else begin
                result_ovf <= 1'b1;
            end
        end else if (prod_valid && prod_ready) begin
            prod_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sm_datapath_fig2.sv
// rtl/sm_datapath_fig2.sv - Fig2 shift-add multiplier datapath; SM_DP_RESULT_BUF_EN enables the held-result buffer
module sm_datapath_fig2
    import sm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   mdin,
    input  logic [WIDTH-1:0]   mrin,
    input  logic               mdld,
    input  logic               mrld,
    input  logic               rsclear,
    input  logic               rsload,
    input  logic               rsshr,
    input  logic               done,
    output logic [WIDTH-1:0]   mr,
    output logic [2*WIDTH-1:0] product,
    output logic               prod_valid,
    input  logic               prod_ready,
    output logic               result_ovf,
    output logic               proto_err
);

    localparam int RSW = RS_W(WIDTH);

    logic [WIDTH-1:0] md;
    logic [RSW-1:0]   rs;
    logic [RSW-1:0]   rs_next;
    logic [WIDTH:0]   rs_upper_sum;

    // Upper part includes the carry bit, so the add never loses a bit before the shift.
    assign rs_upper_sum = rs[RSW-1:WIDTH] + {1'b0, md};

    always_comb begin
        rs_next = rs;
        case (rs_op_decode(rsclear, rsload, rsshr))
            RS_CLEAR: rs_next = '0;
            RS_LOAD:  rs_next = {rs_upper_sum, rs[WIDTH-1:0]};
            RS_SHR:   rs_next = rs >> 1;
            default:  rs_next = rs;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            md        <= '0;
            mr        <= '0;
            rs        <= '0;
            proto_err <= FLAG_RST_VAL;
        end else begin
            if (mdld)
                md <= mdin;
            if (mrld)
                mr <= mrin;
            rs <= rs_next;
            if (multi_strobe(rsclear, rsload, rsshr))
                proto_err <= 1'b1;
        end
    end

`ifdef SM_DP_RESULT_BUF_EN
    sm_result_buf #(
        .W (2 * WIDTH)
    ) u_result_buf (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .candidate  (rs_next[2*WIDTH-1:0]),
        .prod_ready (prod_ready),
        .product    (product),
        .prod_valid (prod_valid),
        .result_ovf (result_ovf)
    );
`else
    logic unused_prod_ready;

    assign unused_prod_ready = prod_ready;
    // Unbuffered: the consumer must take product during the single prod_valid cycle.
    assign product           = rs[2*WIDTH-1:0];
    assign result_ovf        = 1'b0;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE)
            prod_valid <= FLAG_RST_VAL;
        else
            prod_valid <= done;
    end
`endif

endmodule
